// File: rtl/commit_fence_ctrl.sv
// commit_fence_ctrl: sequences FENCE / FENCE.I / SFENCE.VMA for commit port 0.
// The store buffer is drained first. Then the D$, I$ and TLB are flushed as
// the fence type requires. The block ends with one done/flush-pipeline pulse.
// Optional macro COMMIT_FENCE_CTRL_PERF_EN adds the fence and stall counters.
// With the macro undefined, both counter ports are tied to zero.
module commit_fence_ctrl #(
  parameter bit          FLUSH_DCACHE_ON_FENCE = 1'b1,
  parameter int unsigned DRAIN_TIMEOUT         = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic        kill_i,
  input  logic        no_st_pending_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_ack_i,
  output logic        icache_flush_o,
  output logic        tlb_flush_o,
  output logic        done_o,
  output logic        flush_pipeline_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [31:0] fence_cnt_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [1:0]  TYPE_FENCE_I    = 2'd1;
  localparam logic [1:0]  TYPE_SFENCE_VMA = 2'd2;
  localparam bit          WDOG_EN         = (DRAIN_TIMEOUT != 0);
  localparam logic [31:0] WDOG_LAST       = 32'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH_D,
    FLUSH_I,
    TLB,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  type_q;
  logic [31:0] drain_cnt;
  logic [31:0] drain_cnt_nxt;
  logic        timeout_q;
  logic        timeout_nxt;
  logic        accept;

  // A kill in the same cycle as a request blocks acceptance.
  assign req_ready_o = (state == IDLE) && !kill_i;
  assign accept      = req_valid_i && req_ready_o;

  // Next-state choice and the drain watchdog counter.
  // The watchdog pulse is computed one cycle ahead and registered. This lets
  // it appear on the cycle the counter reaches its last value without a
  // combinational path from inputs to the output.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = '0;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (kill_i) begin
          state_nxt = IDLE;
        end else if (no_st_pending_i) begin
          if (type_q == TYPE_FENCE_I) state_nxt = FLUSH_D;
          else if (type_q == TYPE_SFENCE_VMA) state_nxt = TLB;
          else if (FLUSH_DCACHE_ON_FENCE) state_nxt = FLUSH_D;
          else state_nxt = DONE;
        end else begin
          drain_cnt_nxt = (drain_cnt == '1) ? drain_cnt : drain_cnt + 32'd1;
        end
      end
      FLUSH_D: begin
        if (dcache_flush_ack_i) state_nxt = (type_q == TYPE_FENCE_I) ? FLUSH_I : DONE;
      end
      FLUSH_I: state_nxt = DONE;
      TLB:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    timeout_nxt = WDOG_EN && (state_nxt == DRAIN) && (drain_cnt_nxt == WDOG_LAST);
  end

  // State, latched fence type, drain counter and watchdog pulse register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      type_q    <= 2'd0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      timeout_q <= timeout_nxt;
      if (accept) type_q <= req_type_i;
    end
  end

  assign busy_o           = (state != IDLE);
  assign dcache_flush_o   = (state == FLUSH_D);
  assign icache_flush_o   = (state == FLUSH_I);
  assign tlb_flush_o      = (state == TLB);
  assign done_o           = (state == DONE);
  assign flush_pipeline_o = (state == DONE);
  assign timeout_o        = timeout_q;

`ifdef COMMIT_FENCE_CTRL_PERF_EN
  logic [31:0] fence_cnt;
  logic [31:0] stall_cycles;

  // Free-running performance counters that wrap at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fence_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      if (done_o) fence_cnt <= fence_cnt + 32'd1;
      if (busy_o) stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign fence_cnt_o    = fence_cnt;
  assign stall_cycles_o = stall_cycles;
`else
  assign fence_cnt_o    = '0;
  assign stall_cycles_o = '0;
`endif

endmodule
